// File: rtl/alu_exec_unit.sv
// Multi-cycle RV32I/RV64I execute unit: ALU-control decode plus datapath, iterative shifts,
// and an optional radix-2 multiplier compiled in when ALU_MUL_EN is defined.
`timescale 1ns/1ps
module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ALUOp,
    input  logic            opb5,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic            funct7b0,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);
    localparam int SHW = $clog2(XLEN);
    localparam int CW  = SHW + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
        OP_OR, OP_AND, OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_ILL
    } op_e;

    state_e          state_q;
    op_e             op_q;
    logic [XLEN-1:0] val_q;
    logic [CW-1:0]   cnt_q;
    logic            out_valid_q;
    logic [XLEN-1:0] result_q;
    logic            zero_q;
    logic            illegal_q;

    op_e             op_dec;
    logic [XLEN-1:0] simple_res;
    logic [XLEN-1:0] shift_step;
    logic [SHW-1:0]  shamt;
    logic            dec_is_shift;

    assign in_ready  = (state_q == IDLE) & ~reset;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;
    assign shamt     = src_b[SHW-1:0];

    always_comb begin
        op_dec = OP_ILL;
        case (ALUOp)
            2'b00: op_dec = OP_ADD;
            2'b01: op_dec = OP_SUB;
            2'b10: begin
                if (opb5 & funct7b0) begin
`ifdef ALU_MUL_EN
                    case (funct3)
                        3'b000:  op_dec = OP_MUL;
                        3'b001:  op_dec = OP_MULH;
                        3'b010:  op_dec = OP_MULHSU;
                        3'b011:  op_dec = OP_MULHU;
                        default: op_dec = OP_ILL;
                    endcase
`else
                    op_dec = OP_ILL;
`endif
                end else begin
                    case (funct3)
                        3'b000:  op_dec = (opb5 & funct7b5) ? OP_SUB : OP_ADD;
                        3'b001:  op_dec = OP_SLL;
                        3'b010:  op_dec = OP_SLT;
                        3'b011:  op_dec = OP_SLTU;
                        3'b100:  op_dec = OP_XOR;
                        3'b101:  op_dec = funct7b5 ? OP_SRA : OP_SRL;
                        3'b110:  op_dec = OP_OR;
                        default: op_dec = OP_AND;
                    endcase
                end
            end
            default: op_dec = OP_ILL;
        endcase
    end

    assign dec_is_shift = (op_dec == OP_SLL) | (op_dec == OP_SRL) | (op_dec == OP_SRA);

    // Shifts only reach this path with shamt == 0, where the result is src_a unchanged.
    always_comb begin
        simple_res = '0;
        case (op_dec)
            OP_ADD:  simple_res = src_a + src_b;
            OP_SUB:  simple_res = src_a - src_b;
            OP_SLT:  simple_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_SLTU: simple_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            OP_XOR:  simple_res = src_a ^ src_b;
            OP_OR:   simple_res = src_a | src_b;
            OP_AND:  simple_res = src_a & src_b;
            OP_SLL, OP_SRL, OP_SRA: simple_res = src_a;
            default: simple_res = '0;
        endcase
    end

    always_comb begin
        shift_step = val_q >> 1;
        case (op_q)
            OP_SLL:  shift_step = val_q << 1;
            OP_SRA:  shift_step = {val_q[XLEN-1], val_q[XLEN-1:1]};
            default: shift_step = val_q >> 1;
        endcase
    end

`ifdef ALU_MUL_EN
    logic [2*XLEN-1:0] prod_q;
    logic              neg_q;
    logic              dec_is_mul;
    logic              busy_is_mul;
    logic              a_signed;
    logic              b_signed;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod_step;
    logic [2*XLEN-1:0] prod_fin;
    logic [XLEN-1:0]   mul_res;

    assign dec_is_mul  = (op_dec == OP_MUL) | (op_dec == OP_MULH) |
                         (op_dec == OP_MULHSU) | (op_dec == OP_MULHU);
    assign busy_is_mul = (op_q == OP_MUL) | (op_q == OP_MULH) |
                         (op_q == OP_MULHSU) | (op_q == OP_MULHU);
    assign a_signed    = ((op_dec == OP_MULH) | (op_dec == OP_MULHSU)) & src_a[XLEN-1];
    assign b_signed    = (op_dec == OP_MULH) & src_b[XLEN-1];
    assign mag_a       = a_signed ? -src_a : src_a;
    assign mag_b       = b_signed ? -src_b : src_b;

    // Upper half accumulates the multiplicand while the multiplier drains out of the lower half.
    assign mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, val_q} : '0);
    assign prod_step = {mul_sum, prod_q[XLEN-1:1]};
    assign prod_fin  = neg_q ? -prod_step : prod_step;
    assign mul_res   = (op_q == OP_MUL) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= OP_ADD;
            val_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
`ifdef ALU_MUL_EN
            prod_q      <= '0;
            neg_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q <= op_dec;
                        if (dec_is_shift && (shamt != '0)) begin
                            val_q   <= src_a;
                            cnt_q   <= {1'b0, shamt};
                            state_q <= BUSY;
`ifdef ALU_MUL_EN
                        end else if (dec_is_mul) begin
                            val_q   <= mag_a;
                            prod_q  <= {{XLEN{1'b0}}, mag_b};
                            neg_q   <= a_signed ^ b_signed;
                            cnt_q   <= CW'(XLEN);
                            state_q <= BUSY;
`endif
                        end else begin
                            result_q    <= simple_res;
                            zero_q      <= (simple_res == '0);
                            illegal_q   <= (op_dec == OP_ILL);
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - 1'b1;
`ifdef ALU_MUL_EN
                    if (busy_is_mul) begin
                        prod_q <= prod_step;
                        if (cnt_q == CW'(1)) begin
                            result_q    <= mul_res;
                            zero_q      <= (mul_res == '0);
                            illegal_q   <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end else
`endif
                    begin
                        val_q <= shift_step;
                        if (cnt_q == CW'(1)) begin
                            result_q    <= shift_step;
                            zero_q      <= (shift_step == '0);
                            illegal_q   <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit; expectations follow ALU_MUL_EN when it is defined.
`timescale 1ns/1ps
module tb_alu_exec_unit;
    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  ALUOp;
    logic        opb5;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        funct7b0;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [1:0]  op;
        logic        o5;
        logic [2:0]  f3;
        logic        f75;
        logic        f70;
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  lat;
        logic [31:0] res;
        logic        z;
        logic        il;
    } vec_t;

    alu_exec_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(ALUOp), .opb5(opb5), .funct3(funct3), .funct7b5(funct7b5),
        .funct7b0(funct7b0), .src_a(src_a), .src_b(src_b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request, wait for the result (lat counts edges after acceptance), then retire it.
    task automatic do_op(input vec_t v, output int lat, output logic [31:0] r,
                         output logic z, output logic il);
        int n;
        ALUOp = v.op; opb5 = v.o5; funct3 = v.f3; funct7b5 = v.f75; funct7b0 = v.f70;
        src_a = v.a; src_b = v.b; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1 in_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (out_valid) begin lat = k; break; end
        end
        r = result; z = zero; il = illegal;
        out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 00000000", result); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        total++; if ({zero, illegal} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %b want 00", {zero, illegal}); end
        reset = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
        $display("reset: out_valid=%b result=%h in_ready=%b", out_valid, result, in_ready);
    endtask

    task automatic test_arith;
        vec_t t [11];
        int lat; logic [31:0] r; logic z, il;
        t = '{
            '{2'b10, 1'b1, 3'b000, 1'b1, 1'b0, 32'd5,          32'd7,          8'd1, 32'hFFFFFFFE, 1'b0, 1'b0},
            '{2'b00, 1'b0, 3'b111, 1'b0, 1'b0, 32'd3,          32'd4,          8'd1, 32'h00000007, 1'b0, 1'b0},
            '{2'b01, 1'b0, 3'b000, 1'b0, 1'b0, 32'd9,          32'd9,          8'd1, 32'h00000000, 1'b1, 1'b0},
            '{2'b10, 1'b0, 3'b000, 1'b1, 1'b0, 32'd5,          32'd7,          8'd1, 32'h0000000C, 1'b0, 1'b0},
            '{2'b10, 1'b1, 3'b100, 1'b0, 1'b0, 32'hF0F000FF,   32'h0FF00F0F,   8'd1, 32'hFF000FF0, 1'b0, 1'b0},
            '{2'b10, 1'b1, 3'b110, 1'b0, 1'b0, 32'hF0F000FF,   32'h0FF00F0F,   8'd1, 32'hFFF00FFF, 1'b0, 1'b0},
            '{2'b10, 1'b1, 3'b111, 1'b0, 1'b0, 32'hF0F000FF,   32'h0FF00F0F,   8'd1, 32'h00F0000F, 1'b0, 1'b0},
            '{2'b10, 1'b1, 3'b010, 1'b0, 1'b0, 32'hFFFFFFFF,   32'd1,          8'd1, 32'h00000001, 1'b0, 1'b0},
            '{2'b10, 1'b1, 3'b011, 1'b0, 1'b0, 32'hFFFFFFFF,   32'd1,          8'd1, 32'h00000000, 1'b1, 1'b0},
            '{2'b10, 1'b1, 3'b010, 1'b0, 1'b0, 32'd1,          32'hFFFFFFFF,   8'd1, 32'h00000000, 1'b1, 1'b0},
            '{2'b10, 1'b1, 3'b000, 1'b1, 1'b0, 32'h80000000,   32'd1,          8'd1, 32'h7FFFFFFF, 1'b0, 1'b0}
        };
        for (int i = 0; i < 11; i++) begin
            do_op(t[i], lat, r, z, il);
            $display("arith[%0d]: a=%h b=%h result=%h zero=%b illegal=%b lat=%0d", i, t[i].a, t[i].b, r, z, il, lat);
            total++; if (lat !== int'(t[i].lat)) begin bad++; $display("FAIL arith[%0d]_latency: got %0d want %0d", i, lat, t[i].lat); end
            total++; if (r !== t[i].res) begin bad++; $display("FAIL arith[%0d]_result: got %h want %h", i, r, t[i].res); end
            total++; if ({z, il} !== {t[i].z, t[i].il}) begin bad++; $display("FAIL arith[%0d]_flags: got %b want %b", i, {z, il}, {t[i].z, t[i].il}); end
        end
    endtask

    task automatic test_shift;
        vec_t t [7];
        int lat; logic [31:0] r; logic z, il;
        t = '{
            '{2'b10, 1'b1, 3'b101, 1'b1, 1'b0, 32'h80000000, 32'd4,  8'd5,  32'hF8000000, 1'b0, 1'b0},
            '{2'b10, 1'b1, 3'b101, 1'b0, 1'b0, 32'h80000000, 32'd4,  8'd5,  32'h08000000, 1'b0, 1'b0},
            '{2'b10, 1'b1, 3'b001, 1'b0, 1'b0, 32'h12345678, 32'd0,  8'd1,  32'h12345678, 1'b0, 1'b0},
            '{2'b10, 1'b1, 3'b001, 1'b0, 1'b0, 32'h00000001, 32'h21, 8'd2,  32'h00000002, 1'b0, 1'b0},
            '{2'b10, 1'b1, 3'b001, 1'b0, 1'b0, 32'h00000001, 32'd31, 8'd32, 32'h80000000, 1'b0, 1'b0},
            '{2'b10, 1'b0, 3'b101, 1'b1, 1'b0, 32'h80000000, 32'd1,  8'd2,  32'hC0000000, 1'b0, 1'b0},
            '{2'b10, 1'b1, 3'b101, 1'b1, 1'b0, 32'h7FFFFFF0, 32'd4,  8'd5,  32'h07FFFFFF, 1'b0, 1'b0}
        };
        for (int i = 0; i < 7; i++) begin
            do_op(t[i], lat, r, z, il);
            $display("shift[%0d]: a=%h b=%h result=%h lat=%0d", i, t[i].a, t[i].b, r, lat);
            total++; if (lat !== int'(t[i].lat)) begin bad++; $display("FAIL shift[%0d]_latency: got %0d want %0d", i, lat, t[i].lat); end
            total++; if (r !== t[i].res) begin bad++; $display("FAIL shift[%0d]_result: got %h want %h", i, r, t[i].res); end
            total++; if ({z, il} !== {t[i].z, t[i].il}) begin bad++; $display("FAIL shift[%0d]_flags: got %b want %b", i, {z, il}, {t[i].z, t[i].il}); end
        end
    endtask

    task automatic test_illegal_mul;
        vec_t t [5];
        int lat; logic [31:0] r; logic z, il;
`ifdef ALU_MUL_EN
        t = '{
            '{2'b10, 1'b1, 3'b001, 1'b0, 1'b1, 32'hFFFFFFFE, 32'd3,        8'd33, 32'hFFFFFFFF, 1'b0, 1'b0},
            '{2'b10, 1'b1, 3'b000, 1'b0, 1'b1, 32'hFFFFFFFE, 32'd3,        8'd33, 32'hFFFFFFFA, 1'b0, 1'b0},
            '{2'b10, 1'b1, 3'b011, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'd33, 32'hFFFFFFFE, 1'b0, 1'b0},
            '{2'b10, 1'b1, 3'b010, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'd33, 32'hFFFFFFFF, 1'b0, 1'b0},
            '{2'b10, 1'b1, 3'b001, 1'b0, 1'b1, 32'h80000000, 32'h80000000, 8'd33, 32'h40000000, 1'b0, 1'b0}
        };
`else
        t = '{
            '{2'b10, 1'b1, 3'b001, 1'b0, 1'b1, 32'hFFFFFFFE, 32'd3, 8'd1, 32'h0, 1'b1, 1'b1},
            '{2'b10, 1'b1, 3'b000, 1'b0, 1'b1, 32'hFFFFFFFE, 32'd3, 8'd1, 32'h0, 1'b1, 1'b1},
            '{2'b10, 1'b1, 3'b011, 1'b0, 1'b1, 32'd7,        32'd9, 8'd1, 32'h0, 1'b1, 1'b1},
            '{2'b10, 1'b1, 3'b010, 1'b0, 1'b1, 32'd7,        32'd9, 8'd1, 32'h0, 1'b1, 1'b1},
            '{2'b10, 1'b1, 3'b000, 1'b0, 1'b1, 32'd1,        32'd1, 8'd1, 32'h0, 1'b1, 1'b1}
        };
`endif
        for (int i = 0; i < 5; i++) begin
            do_op(t[i], lat, r, z, il);
            $display("mul[%0d]: a=%h b=%h result=%h illegal=%b lat=%0d", i, t[i].a, t[i].b, r, il, lat);
            total++; if (lat !== int'(t[i].lat)) begin bad++; $display("FAIL mul[%0d]_latency: got %0d want %0d", i, lat, t[i].lat); end
            total++; if (r !== t[i].res) begin bad++; $display("FAIL mul[%0d]_result: got %h want %h", i, r, t[i].res); end
            total++; if ({z, il} !== {t[i].z, t[i].il}) begin bad++; $display("FAIL mul[%0d]_flags: got %b want %b", i, {z, il}, {t[i].z, t[i].il}); end
        end
        // ALUOp=11 and an M-encoded divide are illegal in every build.
        t[0] = '{2'b11, 1'b0, 3'b000, 1'b0, 1'b0, 32'd5, 32'd7, 8'd1, 32'h0, 1'b1, 1'b1};
        t[1] = '{2'b10, 1'b1, 3'b100, 1'b0, 1'b1, 32'd5, 32'd7, 8'd1, 32'h0, 1'b1, 1'b1};
        for (int i = 0; i < 2; i++) begin
            do_op(t[i], lat, r, z, il);
            $display("illegal[%0d]: result=%h zero=%b illegal=%b lat=%0d", i, r, z, il, lat);
            total++; if (lat !== 1) begin bad++; $display("FAIL illegal[%0d]_latency: got %0d want 1", i, lat); end
            total++; if ({r, z, il} !== {32'h0, 2'b11}) begin bad++; $display("FAIL illegal[%0d]_outputs: got %h/%b/%b want 00000000/1/1", i, r, z, il); end
        end
    endtask

    task automatic test_stall;
        int n;
        ALUOp = 2'b10; opb5 = 1'b1; funct3 = 3'b000; funct7b5 = 1'b1; funct7b0 = 1'b0;
        src_a = 32'd5; src_b = 32'd7; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_first_valid: got %b want 1", out_valid); end
        // A new request while DONE must be ignored.
        ALUOp = 2'b00; src_a = 32'd1; src_b = 32'd1; in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if ({out_valid, in_ready, result, zero, illegal} !== {2'b10, 32'hFFFFFFFE, 2'b00}) begin
                bad++;
                $display("FAIL stall_hold[%0d]: got v=%b rdy=%b r=%h z=%b il=%b want v=1 rdy=0 r=fffffffe z=0 il=0",
                         c, out_valid, in_ready, result, zero, illegal);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL stall_release: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
        $display("stall: held 10 cycles, result=%h", result);
    endtask

    task automatic test_reset_mid;
        vec_t v;
        int lat; logic [31:0] r; logic z, il;
        int seen;
        for (int pass = 0; pass < 2; pass++) begin
`ifdef ALU_MUL_EN
            if (pass == 1) begin ALUOp = 2'b10; opb5 = 1'b1; funct3 = 3'b000; funct7b0 = 1'b1; src_a = 32'd3; src_b = 32'd5; end
`endif
            if (pass == 0) begin ALUOp = 2'b10; opb5 = 1'b1; funct3 = 3'b001; funct7b0 = 1'b0; src_a = 32'd1; src_b = 32'd31; end
            funct7b5 = 1'b0;
            in_valid = 1'b1;
            @(posedge clk); #1 in_valid = 1'b0;
            repeat (5) @(negedge clk);
            reset = 1'b1;
            #1;
            total++; if ({out_valid, in_ready} !== 2'b00) begin bad++; $display("FAIL reset_mid[%0d]_now: got v=%b rdy=%b want 00", pass, out_valid, in_ready); end
            @(negedge clk); reset = 1'b0;
            seen = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            total++; if (seen !== 0) begin bad++; $display("FAIL reset_mid[%0d]_no_valid: got %0d valid cycles want 0", pass, seen); end
            $display("reset_mid[%0d]: valid cycles after reset=%0d", pass, seen);
        end
        v = '{2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 32'd2, 32'd3, 8'd1, 32'd5, 1'b0, 1'b0};
        do_op(v, lat, r, z, il);
        $display("after_reset: result=%h lat=%0d", r, lat);
        total++; if ({lat == 1, r} !== {1'b1, 32'd5}) begin bad++; $display("FAIL after_reset_op: got lat=%0d r=%h want lat=1 r=00000005", lat, r); end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        ALUOp = 2'b00; opb5 = 1'b0; funct3 = 3'b000; funct7b5 = 1'b0; funct7b0 = 1'b0;
        src_a = '0; src_b = '0;
        test_reset;
        test_arith;
        test_shift;
        test_illegal_mul;
        test_stall;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
